// File: rtl/ifetch_pkg.sv
// Shared widths, reset constants and fetch FSM encoding for the instruction-fetch stage.
package ifetch_pkg;

  localparam int unsigned PC_SIZE    = 32;
  localparam int unsigned INSTR_SIZE = 32;

  localparam logic [PC_SIZE-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_SIZE-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [PC_SIZE-1:0]    PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_WAIT  = 2'd2,
    IF_DROP  = 2'd3
  } if_state_e;

  function automatic logic [PC_SIZE-1:0] word_align(input logic [PC_SIZE-1:0] addr);
    return {addr[PC_SIZE-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// IF/ID slot plus one-entry skid buffer; the skid catches a response that lands
// while decode is stalled on the slot.
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rsp_valid,
  input  logic [PC_SIZE-1:0]    rsp_pc,
  input  logic [INSTR_SIZE-1:0] rsp_instr,
  input  logic                  flush,
  input  logic                  stall,
  output logic                  id_valid,
  output logic [PC_SIZE-1:0]    id_pc,
  output logic [INSTR_SIZE-1:0] id_instr,
  output logic                  skid_valid
);

  logic [PC_SIZE-1:0]    skid_pc;
  logic [INSTR_SIZE-1:0] skid_instr;
  logic                  slot_free;

  assign slot_free = ~id_valid | ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else if (flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_free) begin
      // Skid holds the older instruction, so it drains ahead of any new response.
      if (skid_valid) begin
        id_valid   <= 1'b1;
        id_pc      <= skid_pc;
        id_instr   <= skid_instr;
        skid_valid <= 1'b0;
      end else if (rsp_valid) begin
        id_valid   <= 1'b1;
        id_pc      <= rsp_pc;
        id_instr   <= rsp_instr;
      end else begin
        id_valid   <= 1'b0;
      end
    end else if (rsp_valid) begin
      skid_valid <= 1'b1;
      skid_pc    <= rsp_pc;
      skid_instr <= rsp_instr;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: PC, single-outstanding imem request FSM and redirect
// handling in front of the registered IF/ID slot.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  output logic [PC_SIZE-1:0]    imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_instr,
  input  logic                  bxx_flush,
  input  logic [PC_SIZE-1:0]    bxx_target,
  input  logic                  jalr_en,
  input  logic [PC_SIZE-1:0]    jalr_target,
  input  logic                  id_stall,
  output logic                  id_valid,
  output logic [PC_SIZE-1:0]    id_pc,
  output logic [INSTR_SIZE-1:0] id_instr
);

  if_state_e          state;
  logic [PC_SIZE-1:0] pc_q;
  logic               skid_valid;
  logic               redir;
  logic [PC_SIZE-1:0] redir_target;
  logic               accept;
  logic               deliver;

  assign redir        = bxx_flush | (jalr_en & id_valid & ~id_stall);
  assign redir_target = word_align(bxx_flush ? bxx_target : jalr_target);

  assign imem_req_valid = (state == IF_FETCH) & ~skid_valid;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // A redirect in the response cycle squashes that response.
  assign deliver = (state == IF_WAIT) & imem_rsp_valid & ~redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IF_IDLE;
      pc_q  <= RESET_PC;
    end else begin
      if (redir) begin
        pc_q <= redir_target;
      end else if (deliver) begin
        pc_q <= pc_q + PC_STEP;
      end

      unique case (state)
        IF_IDLE: state <= IF_FETCH;
        IF_FETCH: begin
          if (accept) begin
            state <= redir ? IF_DROP : IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (imem_rsp_valid) begin
            state <= IF_FETCH;
          end else if (redir) begin
            state <= IF_DROP;
          end
        end
        IF_DROP: begin
          if (imem_rsp_valid) begin
            state <= IF_FETCH;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  ifetch_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsp_valid  (deliver),
    .rsp_pc     (pc_q),
    .rsp_instr  (imem_rsp_instr),
    .flush      (redir),
    .stall      (id_stall),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr),
    .skid_valid (skid_valid)
  );

endmodule
